reg_piso_tx: RTL and testbench
==============================

Name: reg_piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the read-out end of the team's parallel D-flip-flop register path.
- Captures a MAX_WIDTH word through a valid/ready load handshake, then shifts it out one bit at a time.
- The serial side has its own per-bit valid/ready handshake, so a slow downstream consumer can stall it.
- Shares the datapath enable convention of the register library.

Parameters:
- MAX_WIDTH, 8, word width in bits; legal values are 2 and above.
- LSB_FIRST, 1, 1 sends d[0] first; 0 sends d[MAX_WIDTH-1] first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- en  input  1  global enable; when low, all state and outputs hold
- load_valid  input  1  parallel word on d is valid
- load_ready  output  1  block can accept a word
- d  input  MAX_WIDTH  parallel word to transmit
- sout  output  1  current serial bit
- sout_valid  output  1  sout holds a valid bit
- sout_ready  input  1  consumer accepts sout this cycle
- busy  output  1  a word is in flight (SHIFT or DONE)
- done  output  1  one-cycle pulse after the last bit transfers
- bit_cnt  output  $clog2(MAX_WIDTH+1)  bits remaining to send

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shreg=0, bit_cnt=0.
  - sout=0, sout_valid=0, busy=0, done=0.
  - load_ready deasserts immediately and returns to 1 on the first edge after rst releases if en=1.
- Reset mid-word aborts the transfer; no done pulse is produced.
- All outputs are registered; load_ready = (state==IDLE) & en.
- en=0:
  - no state change and no transfers on either handshake;
  - outputs hold their values, except load_ready (0) and done (forced 0).
- IDLE:
  - A load transfer occurs on a clock edge with load_valid & load_ready.
  - On that edge: shreg<=d, bit_cnt<=MAX_WIDTH, state<=SHIFT, busy<=1.
  - load_valid has no effect in any other state.
- SHIFT:
  - sout_valid=1.
  - sout = shreg[0] if LSB_FIRST, otherwise shreg[MAX_WIDTH-1].
  - The first bit appears the cycle after the load accept.
  - A bit transfer occurs on an edge with sout_valid & sout_ready & en.
  - On a bit transfer: shreg shifts toward the output end with zero fill, and bit_cnt decrements.
  - sout_ready=0: sout, shreg and bit_cnt hold stable (no glitch, no drop).
  - Transfer with bit_cnt==1: state<=DONE, sout_valid<=0, sout<=0, bit_cnt<=0.
- DONE:
  - Lasts exactly one cycle with done=1, busy=1, load_ready=0, then state<=IDLE.
  - If en=0 while in DONE, state holds and done reads 0. The pulse then fires on the first enabled cycle.
- Throughput: with sout_ready held at 1 and load_valid always high, one word takes MAX_WIDTH+2 cycles (accept, MAX_WIDTH bit cycles, DONE).
- Output rules:
  - sout is 0 whenever sout_valid=0.
  - done never coincides with sout_valid.
- Simultaneous events:
  - rst dominates everything.
  - A load request arriving during SHIFT or DONE is not accepted. The source keeps load_valid high until it sees load_ready.

State machine:
- IDLE -> SHIFT on load transfer.
- SHIFT -> DONE on the last bit transfer.
- DONE -> IDLE after one enabled cycle.
- Any state -> IDLE on rst=0.

Test Plan:
- Basic LSB-first send:
  - Stimulus: LSB_FIRST=1, MAX_WIDTH=8, d=8'h1E, sout_ready=1.
  - Required: sout sequence 0,1,1,1,1,0,0,0 on 8 consecutive cycles starting the cycle after accept.
  - Required: done pulses on the next cycle; load_ready returns one cycle after done.
- Basic MSB-first send:
  - Stimulus: LSB_FIRST=0, d=8'h1E.
  - Required: sout sequence 0,0,0,1,1,1,1,0; bit_cnt reads 8,7,...,1 during the bits, then 0.
- Backpressure:
  - Stimulus: d=8'hF0 LSB-first; drop sout_ready for 3 cycles at bit index 2 and again at bit 5.
  - Required: sout holds its bit value and bit_cnt holds during each stall.
  - Required: bits delivered are 0,0,0,0,1,1,1,1; done occurs 14 cycles after accept.
- Enable freeze:
  - Stimulus: deassert en for 4 cycles mid-word, and separately while in DONE.
  - Required: no bit lost or duplicated; load_ready=0 throughout.
  - Required: the done pulse is delayed until en returns and fires exactly once.
- Reset mid-word:
  - Stimulus: assert rst asynchronously (between clock edges) after 3 bits of 8'hA5.
  - Required: sout_valid, busy and sout read 0 immediately; no done.
  - Required: after release, the next load of 8'h3C transmits cleanly.
- Back-to-back loads:
  - Stimulus: load_valid held high with 3 queued words.
  - Required: each word is accepted exactly once; the inter-word gap is 2 cycles (DONE + accept).
  - Required: load attempts during SHIFT are ignored.

Source files
------------

// File: rtl/reg_piso_tx.sv
// reg_piso_tx: parallel-in serial-out transmitter with load and per-bit valid/ready handshakes.
module reg_piso_tx #(
    parameter int MAX_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [MAX_WIDTH-1:0]                 d,
    output logic                                 sout,
    output logic                                 sout_valid,
    input  logic                                 sout_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(MAX_WIDTH+1)-1:0]       bit_cnt
);
    localparam int CW = $clog2(MAX_WIDTH+1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [MAX_WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0] cnt_n;
    logic ready_q, done_q, out_bit;
    // ready/done are held in registers and masked by en so a disabled block never advertises either
    assign load_ready = ready_q & en;
    assign done = done_q & en;
    assign out_bit = LSB_FIRST ? shreg_n[0] : shreg_n[MAX_WIDTH-1];
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n = bit_cnt;
        case (state)
            IDLE: if (load_valid && load_ready) begin
                shreg_n = d;
                cnt_n = CW'(MAX_WIDTH);
                state_n = SHIFT;
            end
            SHIFT: if (sout_valid && sout_ready && en) begin
                shreg_n = LSB_FIRST ? shreg >> 1 : shreg << 1;
                cnt_n = bit_cnt - CW'(1);
                state_n = (bit_cnt == CW'(1)) ? DONE : SHIFT;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            bit_cnt <= '0;
            sout <= 1'b0;
            sout_valid <= 1'b0;
            busy <= 1'b0;
            ready_q <= 1'b0;
            done_q <= 1'b0;
        end else if (en) begin
            state <= state_n;
            shreg <= shreg_n;
            bit_cnt <= cnt_n;
            sout_valid <= (state_n == SHIFT);
            sout <= (state_n == SHIFT) & out_bit;
            busy <= (state_n != IDLE);
            ready_q <= (state_n == IDLE);
            done_q <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_reg_piso_tx.sv
// tb_reg_piso_tx: directed checks of reg_piso_tx with an LSB-first and an MSB-first instance on shared stimulus.
module tb_reg_piso_tx;
    logic clk, rst, en, load_valid, sout_ready;
    logic [7:0] d;
    logic load_ready, sout, sout_valid, busy, done;
    logic [3:0] bit_cnt;
    logic m_load_ready, m_sout, m_sout_valid, m_busy, m_done;
    logic [3:0] m_bit_cnt;
    int checks = 0;
    int failures = 0;

    reg_piso_tx #(.MAX_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready),
        .d(d), .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
        .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );
    reg_piso_tx #(.MAX_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(m_load_ready),
        .d(d), .sout(m_sout), .sout_valid(m_sout_valid), .sout_ready(sout_ready),
        .busy(m_busy), .done(m_done), .bit_cnt(m_bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] w);
        d = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
        checks++; if (sout_valid !== 1'b0 || sout !== 1'b0) begin failures++; $display("FAIL reset_sout got=%b/%b exp=0/0", sout_valid, sout); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b/%b exp=0/0", busy, done); end
        checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", load_ready); end
    endtask

    task automatic test_lsb_basic;
        logic [7:0] w;
        w = 8'h1E;
        accept(w);
        for (int k = 0; k < 8; k++) begin
            checks++; if (sout_valid !== 1'b1 || sout !== w[k]) begin failures++; $display("FAIL lsb_bit%0d got=%b/%b exp=1/%b", k, sout_valid, sout, w[k]); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL lsb_early_done%0d got=%b exp=0", k, done); end
            step();
        end
        checks++; if (done !== 1'b1 || sout_valid !== 1'b0 || sout !== 1'b0) begin failures++; $display("FAIL lsb_done got=%b/%b/%b exp=1/0/0", done, sout_valid, sout); end
        checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin failures++; $display("FAIL lsb_done_busy got=%b/%b exp=1/0", busy, load_ready); end
        step();
        checks++; if (done !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL lsb_idle got=%b/%b/%b exp=0/1/0", done, load_ready, busy); end
    endtask

    task automatic test_msb_basic;
        logic [7:0] w;
        w = 8'h1E;
        accept(w);
        for (int k = 0; k < 8; k++) begin
            checks++; if (m_sout !== w[7-k]) begin failures++; $display("FAIL msb_bit%0d got=%b exp=%b", k, m_sout, w[7-k]); end
            checks++; if (m_bit_cnt !== 4'(8-k)) begin failures++; $display("FAIL msb_cnt%0d got=%0d exp=%0d", k, m_bit_cnt, 8-k); end
            step();
        end
        checks++; if (m_bit_cnt !== 4'd0 || m_done !== 1'b1) begin failures++; $display("FAIL msb_done got=%0d/%b exp=0/1", m_bit_cnt, m_done); end
        step();
    endtask

    task automatic test_backpressure;
        logic [7:0] w;
        int cyc;
        w = 8'hF0;
        cyc = 0;
        accept(w);
        for (int k = 0; k < 8; k++) begin
            if (k == 2 || k == 5) begin
                sout_ready = 1'b0;
                repeat (3) begin
                    step();
                    cyc++;
                    checks++; if (sout !== w[k] || bit_cnt !== 4'(8-k) || sout_valid !== 1'b1) begin failures++; $display("FAIL bp_stall%0d got=%b/%0d exp=%b/%0d", k, sout, bit_cnt, w[k], 8-k); end
                end
                sout_ready = 1'b1;
            end
            checks++; if (sout !== w[k]) begin failures++; $display("FAIL bp_bit%0d got=%b exp=%b", k, sout, w[k]); end
            step();
            cyc++;
        end
        checks++; if (done !== 1'b1 || cyc != 14) begin failures++; $display("FAIL bp_done got=%b@%0d exp=1@14", done, cyc); end
        step();
    endtask

    task automatic test_enable_freeze;
        logic [7:0] w;
        int pulses;
        w = 8'h5A;
        pulses = 0;
        accept(w);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                en = 1'b0;
                #1;
                repeat (4) begin
                    checks++; if (sout !== w[3] || bit_cnt !== 4'd5 || load_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL en_freeze got=%b/%0d/%b/%b exp=%b/5/0/0", sout, bit_cnt, load_ready, done, w[3]); end
                    step();
                end
                en = 1'b1;
                #1;
            end
            checks++; if (sout !== w[k] || load_ready !== 1'b0) begin failures++; $display("FAIL en_bit%0d got=%b/%b exp=%b/0", k, sout, load_ready, w[k]); end
            step();
        end
        en = 1'b0;
        #1;
        repeat (3) begin
            if (done === 1'b1) pulses++;
            checks++; if (done !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b0) begin failures++; $display("FAIL en_done_hold got=%b/%b/%b exp=0/1/0", done, busy, load_ready); end
            step();
        end
        en = 1'b1;
        #1;
        if (done === 1'b1) pulses++;
        step();
        if (done === 1'b1) pulses++;
        checks++; if (pulses != 1) begin failures++; $display("FAIL en_done_pulses got=%0d exp=1", pulses); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL en_return_ready got=%b exp=1", load_ready); end
    endtask

    task automatic test_reset_midword;
        logic [7:0] w;
        accept(8'hA5);
        repeat (3) step();
        #3;
        rst = 1'b0;
        #1;
        checks++; if (sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got=%b/%b/%b exp=0/0/0", sout_valid, busy, sout); end
        checks++; if (load_ready !== 1'b0 || bit_cnt !== 4'd0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b/%0d/%b exp=0/0/0", load_ready, bit_cnt, done); end
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++; if (done !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("FAIL rstmid_release got=%b/%b exp=0/1", done, load_ready); end
        w = 8'h3C;
        accept(w);
        for (int k = 0; k < 8; k++) begin
            checks++; if (sout !== w[k] || sout_valid !== 1'b1) begin failures++; $display("FAIL rstmid_bit%0d got=%b exp=%b", k, sout, w[k]); end
            step();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rstmid_done got=%b exp=1", done); end
        step();
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        logic [7:0] rx [3];
        int acc [3];
        int n, wi, bp;
        words[0] = 8'h81; words[1] = 8'h7E; words[2] = 8'hC3;
        rx[0] = 8'h00; rx[1] = 8'h00; rx[2] = 8'h00;
        acc[0] = -1; acc[1] = -1; acc[2] = -1;
        n = 0; wi = 0; bp = 0;
        d = words[0];
        load_valid = 1'b1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            if (load_valid && load_ready) begin
                if (n < 3) acc[n] = cyc;
                n++;
            end
            if (sout_valid) begin
                checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_shift got=%b exp=0 cyc=%0d", load_ready, cyc); end
                if (wi < 3) rx[wi][bp] = sout;
                bp++;
                if (bp == 8) begin bp = 0; wi++; end
            end
            step();
            if (n < 3) d = words[n];
            else load_valid = 1'b0;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
        checks++; if (acc[1] - acc[0] != 10 || acc[2] - acc[1] != 10) begin failures++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=0,10,20", acc[0], acc[1], acc[2]); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx[i] !== words[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, rx[i], words[i]); end
        end
        checks++; if (busy !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/1", busy, load_ready); end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b1;
        load_valid = 1'b0;
        sout_ready = 1'b1;
        d = 8'h00;
        test_reset();
        test_lsb_basic();
        test_msb_basic();
        test_backpressure();
        test_enable_freeze();
        test_reset_midword();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
